// File: rtl/pc_unit_if.sv
// ---------------------------------------------------------------------------
// pc_unit_if
// Groups the control/datapath signals exchanged with the program-counter
// unit.
//   master : drives estado, stall, pcsrc, immediate, rs1;
//            observes PC, pc_link, epc, trap, halted, retired
//   slave  : the pc_unit side (mirror of master)
// ---------------------------------------------------------------------------
interface pc_unit_if #(
    parameter int XLEN  = 32,
    parameter int IMM_W = 21
);
    logic [2:0]       estado;     // control FSM state
    logic             stall;      // suppresses the commit when high
    logic [1:0]       pcsrc;      // 00/11 seq, 01 PC-relative, 10 JALR
    logic [IMM_W-1:0] immediate;  // signed byte offset
    logic [XLEN-1:0]  rs1;        // JALR base register
    logic [XLEN-1:0]  PC;         // registered program counter
    logic [XLEN-1:0]  pc_link;    // PC + step, link value for JAL/JALR
    logic [XLEN-1:0]  epc;        // PC of the instruction whose target faulted
    logic             trap;       // high while in TRAP
    logic             halted;     // high while in HALT
    logic [31:0]      retired;    // committed non-faulting updates

    modport master (
        output estado, stall, pcsrc, immediate, rs1,
        input  PC, pc_link, epc, trap, halted, retired
    );

    modport slave (
        input  estado, stall, pcsrc, immediate, rs1,
        output PC, pc_link, epc, trap, halted, retired
    );
endinterface

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program-counter unit for the multi-cycle RISC-V datapath. Once per
// instruction (estado == UPDATE_STATE, no stall, not halted) it commits the
// next PC from the sequential, PC-relative or JALR source. Misaligned
// targets divert to TRAP_VECTOR and save the faulting PC in epc; a fault
// while already trapped halts the unit until reset.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : pc_unit_if.slave (estado, stall, pcsrc, immediate, rs1 in;
//            PC, pc_link, epc, trap, halted, retired out)
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter int              IMM_W        = 21,
    parameter bit              WORD_ADDR    = 1'b1,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h40),
    parameter logic [2:0]      UPDATE_STATE = 3'b110
) (
    input logic   clk,
    input logic   rst_n,
    pc_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] STEP = WORD_ADDR ? XLEN'(1) : XLEN'(4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [31:0]     retired_q, retired_d;

    logic signed [XLEN-1:0] simm;
    logic [XLEN-1:0]        ba;
    logic [XLEN-1:0]        target;
    logic                   fault;
    logic                   commit;
    logic                   ret_match;

    // Size cast of a signed operand sign-extends the decoder immediate.
    assign simm = XLEN'($signed(bus.immediate));

    // JALR base address with bit 0 cleared, as the ISA requires.
    assign ba = (bus.rs1 + simm) & ~XLEN'(1);

    assign commit = (bus.estado == UPDATE_STATE) && !bus.stall && (state_q != ST_HALT);

    // ---------------------------------------------------------------
    // Target selection and misalignment detection
    // ---------------------------------------------------------------
    // NOTE: every variable assigned in an always_comb gets a default at the
    // top of the block so no path leaves it unassigned (no latch inferred).
    always_comb begin
        target = pc_q + STEP;
        fault  = 1'b0;
        unique case (bus.pcsrc)
            2'b01: begin
                if (WORD_ADDR) begin
                    // Byte offset converted to words; low bits must be zero.
                    target = pc_q + XLEN'(simm >>> 2);
                    fault  = |simm[1:0];
                end else begin
                    target = pc_q + simm;
                    fault  = |target[1:0];
                end
            end
            2'b10: begin
                target = WORD_ADDR ? (ba >> 2) : ba;
                fault  = ba[1];
            end
            default: begin
                target = pc_q + STEP;
                fault  = 1'b0;
            end
        endcase
    end

    // Returning to the instruction after the faulting one clears TRAP.
    assign ret_match = (target == (epc_q + STEP));

    // ---------------------------------------------------------------
    // State register (FSM state plus datapath registers)
    // ---------------------------------------------------------------
    // NOTE: reset is sampled on the clock edge (synchronous), and all state
    // uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_VECTOR;
            epc_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            retired_q <= retired_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        retired_d = retired_q;

        if (commit) begin
            if (!fault) begin
                pc_d      = target;
                retired_d = retired_q + 32'd1;
                if (state_q == ST_TRAP && ret_match) begin
                    state_d = ST_RUN;
                end
            end else if (state_q == ST_RUN) begin
                pc_d    = TRAP_VECTOR;
                epc_d   = pc_q;
                state_d = ST_TRAP;
            end else begin
                // Fault while trapped: freeze PC/epc for post-mortem.
                state_d = ST_HALT;
            end
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    always_comb begin
        bus.PC      = pc_q;
        bus.pc_link = pc_q + STEP;
        bus.epc     = epc_q;
        bus.retired = retired_q;
        bus.trap    = (state_q == ST_TRAP);
        bus.halted  = (state_q == ST_HALT);
    end

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
// Drives one word-addressed and one byte-addressed pc_unit with identical
// stimulus and compares both against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  estado    = '0;
    logic        stall     = 1'b0;
    logic [1:0]  pcsrc     = '0;
    logic [20:0] immediate = '0;
    logic [31:0] rs1       = '0;

    pc_unit_if #(.XLEN(32), .IMM_W(21)) bus_w ();
    pc_unit_if #(.XLEN(32), .IMM_W(21)) bus_b ();

    assign bus_w.estado = estado;    assign bus_b.estado = estado;
    assign bus_w.stall = stall;      assign bus_b.stall = stall;
    assign bus_w.pcsrc = pcsrc;      assign bus_b.pcsrc = pcsrc;
    assign bus_w.immediate = immediate; assign bus_b.immediate = immediate;
    assign bus_w.rs1 = rs1;          assign bus_b.rs1 = rs1;

    pc_unit #(.WORD_ADDR(1'b1)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));
    pc_unit #(.WORD_ADDR(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (index 0 = byte, 1 = word) --------
    localparam longint M32 = 64'sh1_0000_0000;
    localparam longint TRAP_VEC = 64'h40;

    longint m_pc[2], m_epc[2], m_ret[2];
    int     m_st[2];   // 0 run, 1 trap, 2 halt

    function automatic longint wrap(input longint s);
        return ((s % M32) + M32) % M32;
    endfunction

    function automatic void model_target(input int word, input longint pc,
                                         input logic [1:0] src, input logic [20:0] im,
                                         input logic [31:0] r1,
                                         output longint tgt, output bit flt);
        longint off  = longint'($signed(im));
        longint step = (word != 0) ? 64'd1 : 64'd4;
        longint ba;
        flt = 1'b0;
        if (src == 2'b01) begin
            if (word != 0) begin
                flt = (off % 4) != 0;
                tgt = wrap(pc + off / 4);
            end else begin
                tgt = wrap(pc + off);
                flt = (tgt % 4) != 0;
            end
        end else if (src == 2'b10) begin
            ba  = wrap(longint'(r1) + off);
            ba  = ba - (ba % 2);
            flt = ((ba / 2) % 2) != 0;
            tgt = (word != 0) ? ba / 4 : ba;
        end else begin
            tgt = wrap(pc + step);
        end
    endfunction

    function automatic void model_step(input int i, input logic rn);
        longint tgt;
        bit     flt;
        longint step = (i != 0) ? 64'd1 : 64'd4;
        if (!rn) begin
            m_pc[i] = 0; m_epc[i] = 0; m_ret[i] = 0; m_st[i] = 0;
        end else if (estado == 3'b110 && !stall && m_st[i] != 2) begin
            model_target(i, m_pc[i], pcsrc, immediate, rs1, tgt, flt);
            if (!flt) begin
                if (m_st[i] == 1 && tgt == wrap(m_epc[i] + step)) m_st[i] = 0;
                m_pc[i]  = tgt;
                m_ret[i] = wrap(m_ret[i] + 1);
            end else if (m_st[i] == 0) begin
                m_epc[i] = m_pc[i];
                m_pc[i]  = TRAP_VEC;
                m_st[i]  = 1;
            end else begin
                m_st[i] = 2;
            end
        end
    endfunction

    task automatic check_dut(input string p, input int i,
                             input logic [31:0] pc, input logic [31:0] link,
                             input logic [31:0] epc, input logic [31:0] ret,
                             input logic tr, input logic hl);
        longint step = (i != 0) ? 64'd1 : 64'd4;
        check({p, "_pc"},      pc,   32'(m_pc[i]));
        check({p, "_link"},    link, 32'(wrap(m_pc[i] + step)));
        check({p, "_epc"},     epc,  32'(m_epc[i]));
        check({p, "_retired"}, ret,  32'(m_ret[i]));
        check({p, "_trap"},    32'(tr), 32'(m_st[i] == 1));
        check({p, "_halted"},  32'(hl), 32'(m_st[i] == 2));
    endtask

    // One clock: drive at negedge, predict, clock, compare at next negedge.
    task automatic cycle(input logic [2:0] e, input logic s, input logic [1:0] src,
                         input logic [20:0] im, input logic [31:0] r1, input logic rn);
        estado = e; stall = s; pcsrc = src; immediate = im; rs1 = r1; rst_n = rn;
        model_step(0, rn);
        model_step(1, rn);
        @(posedge clk);
        @(negedge clk);
        check_dut("b", 0, bus_b.PC, bus_b.pc_link, bus_b.epc, bus_b.retired, bus_b.trap, bus_b.halted);
        check_dut("w", 1, bus_w.PC, bus_w.pc_link, bus_w.epc, bus_w.retired, bus_w.trap, bus_w.halted);
    endtask

    localparam logic [2:0] UPD = 3'b110;

    initial begin
        logic [2:0]  e;
        logic        s;
        logic [1:0]  src;
        logic [20:0] im;
        logic [31:0] r1;
        logic        rn;

        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 0; m_epc[i] = 0; m_ret[i] = 0; m_st[i] = 0;
        end
        @(negedge clk);

        // Reset, then three sequential commits.
        cycle(3'b000, 1'b0, 2'b00, '0, '0, 1'b0);
        check("rst_pc_w", bus_w.PC, 32'd0);
        for (int k = 0; k < 3; k++) cycle(UPD, 1'b0, 2'b00, '0, '0, 1'b1);
        check("seq_pc_w", bus_w.PC, 32'd3);
        check("seq_ret_w", bus_w.retired, 32'd3);
        check("seq_link_w", bus_w.pc_link, 32'd4);
        check("seq_pc_b", bus_b.PC, 32'd12);
        cycle(3'b101, 1'b0, 2'b00, '0, '0, 1'b1);
        check("hold_pc_w", bus_w.PC, 32'd3);

        // Branch sign handling (word PC = 10).
        cycle(UPD, 1'b0, 2'b10, '0, 32'd40, 1'b1);
        check("jalr10_w", bus_w.PC, 32'd10);
        cycle(UPD, 1'b0, 2'b01, 21'h1FFFF8, '0, 1'b1);
        check("br_neg_w", bus_w.PC, 32'd8);
        cycle(UPD, 1'b0, 2'b10, '0, 32'd40, 1'b1);
        cycle(UPD, 1'b0, 2'b01, 21'd12, '0, 1'b1);
        check("br_pos_w", bus_w.PC, 32'd13);
        cycle(UPD, 1'b1, 2'b01, 21'd12, '0, 1'b1);
        check("stall_pc_w", bus_w.PC, 32'd13);

        // JALR in byte mode, then a misaligned JALR fault.
        cycle(UPD, 1'b0, 2'b10, '0, 32'h100, 1'b1);
        check("link_b", bus_b.pc_link, 32'h104);
        cycle(UPD, 1'b0, 2'b10, 21'd1, 32'h203, 1'b1);
        check("jalr_b", bus_b.PC, 32'h204);
        cycle(UPD, 1'b0, 2'b10, '0, 32'h100, 1'b1);
        cycle(UPD, 1'b0, 2'b10, '0, 32'h202, 1'b1);
        check("flt_pc_b", bus_b.PC, 32'h40);
        check("flt_epc_b", bus_b.epc, 32'h100);
        check("flt_trap_b", 32'(bus_b.trap), 32'd1);

        // Trap return, re-fault, double fault.
        cycle(UPD, 1'b0, 2'b10, '0, 32'h104, 1'b1);
        check("ret_trap_b", 32'(bus_b.trap), 32'd0);
        cycle(UPD, 1'b0, 2'b10, '0, 32'h202, 1'b1);
        cycle(UPD, 1'b0, 2'b10, '0, 32'h202, 1'b1);
        check("dbl_halt_b", 32'(bus_b.halted), 32'd1);
        for (int k = 0; k < 10; k++) cycle(UPD, 1'b0, 2'b00, '0, '0, 1'b1);
        check("halt_pc_b", bus_b.PC, 32'h40);
        cycle(3'b000, 1'b0, 2'b00, '0, '0, 1'b0);
        check("halt_rst_b", 32'(bus_b.halted), 32'd0);
        check("halt_rst_pc_b", bus_b.PC, 32'd0);

        // Address wrap-around.
        cycle(UPD, 1'b0, 2'b10, '0, 32'hFFFF_FFFC, 1'b1);
        cycle(UPD, 1'b0, 2'b00, '0, '0, 1'b1);
        check("wrap_pc_b", bus_b.PC, 32'd0);

        // Reset coinciding with a faulting commit.
        cycle(UPD, 1'b0, 2'b10, '0, 32'h100, 1'b1);
        cycle(UPD, 1'b0, 2'b10, '0, 32'h202, 1'b0);
        check("rstflt_trap_b", 32'(bus_b.trap), 32'd0);
        check("rstflt_epc_b", bus_b.epc, 32'd0);
        cycle(3'b000, 1'b0, 2'b00, '0, '0, 1'b1);

        // Randomized run.
        for (int k = 0; k < 3000; k++) begin
            e   = ($urandom_range(0, 3) != 0) ? UPD : 3'($urandom_range(0, 7));
            s   = ($urandom_range(0, 7) == 0);
            src = 2'($urandom);
            im  = 21'($urandom);
            r1  = $urandom;
            if ($urandom_range(0, 3) != 0) im[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) r1[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) im = 21'($signed(im) >>> 8);
            if (m_st[0] == 1 && $urandom_range(0, 2) == 0) begin
                src = 2'b10; im = '0; r1 = 32'(wrap(m_epc[0] + 4));
            end else if (m_st[1] == 1 && $urandom_range(0, 2) == 0) begin
                src = 2'b10; im = '0; r1 = 32'(wrap(m_epc[1] + 1) * 4);
            end
            rn = ($urandom_range(0, 199) != 0);
            if (m_st[0] == 2 && m_st[1] == 2 && $urandom_range(0, 7) == 0) rn = 1'b0;
            cycle(e, s, src, im, r1, rn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
